// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: reset/NOP constants and the
// fetch-control state encoding.
package cpu_defs;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // SLL $0,$0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    FAULT   = 2'd2
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: word address and enable out,
// combinational read data back in the same cycle.
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;

  modport master (output imem_addr, output imem_en, input  imem_data);
  modport slave  (input  imem_addr, input  imem_en, output imem_data);

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: jump-over-branch redirect priority, buffered target,
// sequential pc+4 (wraps mod 2^32) and target alignment check.
module fetch_next_pc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic        use_pend,
  input  logic [31:0] pend_tgt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] tgt,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    redirect = jump | branch_taken;
    tgt      = jump ? jump_target : branch_target;
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    if (redirect) begin
      next_pc = tgt;
    end else if (use_pend) begin
      next_pc = pend_tgt;
    end
    // Only redirect targets can be misaligned; pc+4 from an aligned pc never is.
    misaligned = (redirect | use_pend) & is_misaligned(next_pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and captures
// each fetched word into the IF/ID register with redirect, stall and fault control.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  input  logic                jump,
  input  logic [31:0]         jump_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc4,
  output logic                if_id_valid,
  output logic                addr_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         addr_err_q, addr_err_d;

  logic         redirect;
  logic [31:0]  tgt;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;

  fetch_next_pc u_next_pc (
    .pc            (pc_q),
    .use_pend      (state_q == PENDING),
    .pend_tgt      (pend_tgt_q),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .redirect      (redirect),
    .tgt           (tgt),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    addr_err_d = addr_err_q;

    if (state_q == FAULT) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      // IF/ID: flush squashes, otherwise a non-stalled edge latches the word at pc
      // (including the delay slot of a redirect).
      if (flush) begin
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = imem.imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end

      // A flush owns the pipeline, so the PC advances even while stalled.
      if (flush || !stall) begin
        if (misaligned) begin
          addr_err_d = 1'b1;
          state_d    = FAULT;
        end else begin
          pc_d    = next_pc;
          state_d = RUN;
        end
      end else if (redirect) begin
        pend_tgt_d = tgt;
        state_d    = PENDING;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'd0;
      instr_q    <= NOP_WORD;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_en   = (state_q != FAULT) && !stall;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc4      = pc4_q;
  assign if_id_valid    = valid_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each directed step queues its hand-computed
// post-edge state and a monitor compares it after the edge.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        addr_err;

  fetch_unit_if imem ();

  fetch_unit dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (imem.master),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .addr_err      (addr_err)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: two real words at 0 and 4, address-derived words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2401002C;
    if (a == 32'h4) return 32'h90220000;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign imem.imem_data = mem_word(imem.imem_addr);

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
    logic        en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (pc === mon_e.pc && if_id_instr === mon_e.instr && if_id_pc4 === mon_e.pc4 &&
          if_id_valid === mon_e.valid && addr_err === mon_e.err && imem.imem_en === mon_e.en) begin
        n_pass++;
        $display("step %0d ok: pc=%08h instr=%08h pc4=%08h valid=%0b err=%0b en=%0b",
                 mon_e.id, pc, if_id_instr, if_id_pc4, if_id_valid, addr_err, imem.imem_en);
      end else begin
        $display("FAIL step_%0d: got pc=%08h instr=%08h pc4=%08h valid=%0b err=%0b en=%0b, expected pc=%08h instr=%08h pc4=%08h valid=%0b err=%0b en=%0b",
                 mon_e.id, pc, if_id_instr, if_id_pc4, if_id_valid, addr_err, imem.imem_en,
                 mon_e.pc, mon_e.instr, mon_e.pc4, mon_e.valid, mon_e.err, mon_e.en);
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid,
                      input logic e_err, input logic e_en);
    exp_t e;
    Reset         = rst;
    stall         = st;
    flush         = fl;
    branch_taken  = br;
    branch_target = bt;
    jump          = j;
    jump_target   = jt;
    e.id    = step_id;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    e.valid = e_valid;
    e.err   = e_err;
    e.en    = e_en;
    sb.push_back(e);
    step_id++;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    //   rst st fl br bt            j  jt             pc            instr                   pc4           v  err en
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 32'h00000000,           32'h00000000, 0, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 32'h2401002C,           32'h00000004, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000008, 32'h90220000,           32'h00000008, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        1, 32'h1C,       32'h0000001C, mem_word(32'h08),       32'h0000000C, 1, 0, 1);
    step(0, 0, 0, 1, 32'h14,       0, 32'h0,        32'h00000014, mem_word(32'h1C),       32'h00000020, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000018, mem_word(32'h14),       32'h00000018, 1, 0, 1);
    // redirect held across a 3-cycle stall, applied on the first free edge
    step(0, 1, 0, 1, 32'h24,       0, 32'h0,        32'h00000018, mem_word(32'h14),       32'h00000018, 1, 0, 0);
    step(0, 1, 0, 1, 32'h24,       0, 32'h0,        32'h00000018, mem_word(32'h14),       32'h00000018, 1, 0, 0);
    step(0, 1, 0, 1, 32'h24,       0, 32'h0,        32'h00000018, mem_word(32'h14),       32'h00000018, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000024, mem_word(32'h18),       32'h0000001C, 1, 0, 1);
    // latest buffered redirect wins
    step(0, 1, 0, 1, 32'h30,       0, 32'h0,        32'h00000024, mem_word(32'h18),       32'h0000001C, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0,        1, 32'h34,       32'h00000024, mem_word(32'h18),       32'h0000001C, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000034, mem_word(32'h24),       32'h00000028, 1, 0, 1);
    // jump beats branch
    step(0, 0, 0, 1, 32'h80,       1, 32'h40,       32'h00000040, mem_word(32'h34),       32'h00000038, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000044, mem_word(32'h40),       32'h00000044, 1, 0, 1);
    // flush with stall still advances pc
    step(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h00000048, 32'h00000000,           32'h00000000, 0, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h0000004C, 32'h00000000,           32'h00000000, 0, 0, 1);
    // misaligned jump: delay slot latched, then NOPs while frozen
    step(0, 0, 0, 0, 32'h0,        1, 32'h22,       32'h0000004C, mem_word(32'h4C),       32'h00000050, 1, 1, 0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000004C, 32'h00000000,           32'h00000000, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0,        1, 32'h100,      32'h0000004C, 32'h00000000,           32'h00000000, 0, 1, 0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 32'h00000000,           32'h00000000, 0, 0, 1);
    // pc+4 wrap
    step(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h2401002C,           32'h00000004, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, mem_word(32'hFFFFFFFC), 32'h00000000, 1, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 32'h2401002C,           32'h00000004, 1, 0, 1);
    // misaligned buffered target faults when applied
    step(0, 1, 0, 1, 32'h0A,       0, 32'h0,        32'h00000004, 32'h2401002C,           32'h00000004, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 32'h90220000,           32'h00000008, 1, 1, 0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 32'h00000000,           32'h00000000, 0, 1, 0);
    // reset discards a pending redirect
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 32'h00000000,           32'h00000000, 0, 0, 1);
    step(0, 1, 0, 1, 32'h50,       0, 32'h0,        32'h00000000, 32'h00000000,           32'h00000000, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 32'h00000000,           32'h00000000, 0, 0, 1);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 32'h2401002C,           32'h00000004, 1, 0, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS-style core. Owns the program counter and drives the byte-addressed, big-endian instruction memory. Captures each fetched word into the IF/ID pipeline register consumed by decode/control. Supports ID-stage redirects (branch/jump with one architectural delay slot), pipeline stalls, flushes, a pending-redirect buffer for redirects that arrive during a stall, and a sticky misaligned-target fault.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_WORD, 32'h00000000, instruction injected on flush/reset (SLL $0,$0,0)

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID (hazard unit)
- flush  in  1  replace IF/ID with NOP_WORD, valid=0
- branch_taken  in  1  redirect from ID, branch resolved taken
- branch_target  in  32  branch destination
- jump  in  1  redirect from ID, unconditional jump
- jump_target  in  32  jump destination
- imem_data  in  32  instruction word at imem_addr, combinational same cycle
- imem_addr  out  32  = pc
- imem_en  out  1  1 in RUN/PENDING when not stalled, 0 in FAULT or stall
- pc  out  32  current fetch PC
- if_id_instr  out  32  latched instruction
- if_id_pc4  out  32  PC+4 of latched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- addr_err  out  1  sticky misaligned redirect target fault

## Operation
- States: RUN, PENDING (redirect buffered during stall), FAULT.
- Redirect select: jump has priority over branch_taken when both are asserted. Selected target goes to tgt; redirect = jump | branch_taken.
- Delay slot: a redirect does not flush IF/ID. The word fetched in the redirect cycle (pc of delay slot) is latched normally.
- RUN, no stall: IF/ID <= {imem_data, pc+4, 1}. pc <= redirect ? tgt : pc+4.
- RUN, stall, no redirect: pc and IF/ID hold.
- RUN, stall & redirect: pc and IF/ID hold. pend_tgt <= tgt. Go to PENDING.
- PENDING, stall: hold everything. A new redirect overwrites pend_tgt (latest wins).
- PENDING, no stall: IF/ID latches normally. pc <= redirect ? tgt : pend_tgt. Return to RUN.
- Misalignment: if a target being applied to pc has bits [1:0] != 0, pc is not updated, addr_err <= 1, and the state goes to FAULT. This check also applies to pend_tgt.
- FAULT: pc frozen. Every cycle IF/ID <= {NOP_WORD, 0, 0}. imem_en = 0. Only Reset exits FAULT.
- flush: IF/ID <= {NOP_WORD, 0, 0} regardless of stall. PC and state update as if stall were 0. Flush+stall therefore advances pc, because the redirect or squash owns the pipeline.
- pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no flag.

## Timing
- Reset (synchronous, highest priority): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, addr_err=0, state=RUN, pend_tgt=0.
- Fetch latency: a word at pc appears on if_id_instr one edge later.
- Redirect seen at edge N (from the branch in ID): delay slot is latched at N. Target word is latched at N+1.
- Redirect during stall: target applied on the first edge with stall=0.
- Reset mid-PENDING or in FAULT: discards pend_tgt and returns to RUN at RESET_PC on the next edge.
- Priority per edge: Reset > FAULT > flush > stall > redirect > sequential.

## Structure
- Shared package cpu_defs: NOP_WORD, RESET_PC default, fetch_state_t enum {RUN, PENDING, FAULT}.
- Sub-module fetch_next_pc: combinational redirect select, pc+4, and alignment check. Outputs next_pc and misaligned.
- The PC register, state register, and IF/ID register live in fetch_unit.

## Test plan
- Reset then run, imem word 0x2401002C at 0, 0x90220000 at 4: after edge 1 if_id_instr=0x2401002C, pc4=4, valid=1. After edge 2 instr=0x90220000, pc=8.
- BGTZ taken with branch_target=0x14 while pc=0x1C: edge latches the 0x1C delay slot, pc=0x14. Next edge latches the word at 0x14.
- stall=1 with branch_taken, target 0x24, for 3 cycles: pc and IF/ID unchanged, state PENDING. First unstalled edge: pc=0x24, state RUN.
- jump=1 (target 0x40) and branch_taken=1 (target 0x80) in the same cycle: pc=0x40.
- jump_target=0x22: addr_err=1, pc frozen, valid=0 on every following edge. Reset returns pc=0, addr_err=0.
- flush=1 with stall=1 at pc=0x10: IF/ID=NOP_WORD, valid=0, pc=0x14. pc=0xFFFFFFFC advancing gives pc=0.
